bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 93 +++++++++
 tb/tb_bcd_to_bin.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - three-digit BCD to 10-bit binary converter, reverse double-dabble
module bcd_to_bin (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [9:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic [3:0]  cnt;

  logic [21:0] shifted;
  logic [11:0] bcd_next;
  logic [9:0]  bin_next;
  logic        invalid;

  function automatic logic [3:0] adjust(input logic [3:0] d);
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  // One step: shift {bcd,bin} right, then pull back any digit that borrowed a half-ten.
  always_comb begin
    shifted  = {bcd, bin} >> 1;
    bin_next = shifted[9:0];
    bcd_next = {adjust(shifted[21:18]), adjust(shifted[17:14]), adjust(shifted[13:10])};
    invalid  = (bcd_hundreds > 4'd9) || (bcd_tens > 4'd9) || (bcd_ones > 4'd9);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bcd    <= '0;
      bin    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd <= {bcd_hundreds, bcd_tens, bcd_ones};
            bin <= '0;
            cnt <= '0;
            if (invalid) begin
              state  <= DONE;
              done   <= 1'b1;
              error  <= 1'b1;
              result <= '0;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          bin <= bin_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            error  <= 1'b0;
            result <= bin_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] bcd_hundreds = '0;
  logic [3:0] bcd_tens = '0;
  logic [3:0] bcd_ones = '0;
  logic       busy, done, error;
  logic [9:0] result;

  int total = 0;
  int bad = 0;

  bcd_to_bin dut (
    .clock(clock), .reset(reset), .start(start),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .busy(busy), .done(done), .error(error), .result(result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one request and checks latency, busy length, strobe width and values against plain arithmetic.
  task automatic convert(input int h, input int t, input int o);
    int exp_val, exp_err, exp_lat, k, busy_cnt, seen;
    exp_err = (h > 9 || t > 9 || o > 9) ? 1 : 0;
    exp_val = exp_err ? 0 : h * 100 + t * 10 + o;
    exp_lat = exp_err ? 0 : 10;
    @(negedge clock);
    bcd_hundreds = 4'(h); bcd_tens = 4'(t); bcd_ones = 4'(o);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    bcd_hundreds = 4'($urandom_range(0, 15));
    bcd_tens     = 4'($urandom_range(0, 15));
    bcd_ones     = 4'($urandom_range(0, 15));
    busy_cnt = 0; seen = -1;
    for (k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) seen = k;
    end
    chk($sformatf("latency %0d%0d%0d", h, t, o), seen, exp_lat);
    chk($sformatf("busy_len %0d%0d%0d", h, t, o), busy_cnt, exp_lat);
    chk($sformatf("result %0d%0d%0d", h, t, o), int'(result), exp_val);
    chk($sformatf("error %0d%0d%0d", h, t, o), int'(error), exp_err);
    @(negedge clock);
    chk("done_width", int'(done), 0);
    chk("result_hold", int'(result), exp_val);
  endtask

  initial begin
    int cyc, dones, last, gaps_ok, n;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clock);
    reset = 1'b1;

    convert(0, 0, 0);
    convert(9, 9, 9);
    convert(2, 5, 5);
    convert(10, 0, 0);
    convert(1, 2, 3);
    convert(0, 0, 9);
    convert(9, 0, 15);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        convert($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      else
        convert($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    end

    // start pulsed while busy must be dropped
    @(negedge clock);
    bcd_hundreds = 4'd4; bcd_tens = 4'd5; bcd_ones = 4'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    bcd_hundreds = 4'd7; bcd_tens = 4'd8; bcd_ones = 4'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0; n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done) begin dones++; n = int'(result); end
    end
    chk("ignored_start_dones", dones, 1);
    chk("ignored_start_result", n, 456);

    // async reset during iteration 5
    @(negedge clock);
    bcd_hundreds = 4'd9; bcd_tens = 4'd9; bcd_ones = 4'd9; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_error", int'(error), 0);
    chk("abort_result", int'(result), 0);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    convert(0, 4, 2);

    // start held high: one completion every 12 cycles
    @(negedge clock);
    bcd_hundreds = 4'd1; bcd_tens = 4'd0; bcd_ones = 4'd0; start = 1'b1;
    dones = 0; last = -1; gaps_ok = 1;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        chk("b2b_result", int'(result), 100);
        if (last >= 0 && cyc - last != 12) gaps_ok = 0;
        last = cyc;
      end
    end
    chk("b2b_count", dones, 4);
    chk("b2b_period", gaps_ok, 1);
    start = 1'b0;
    repeat (15) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
